// File: rtl/pakout_gen.sv
// NCH-channel req/ack packet source: per-channel address sweep, data counter, continuous or counted bursts.
// Arm to o_req is 2 cycles, min packet period is 3 cycles; a channel holds its fields in REQ until i_ack.
`timescale 1ns/1ps

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module pakout_gen #(
    parameter int NCH      = 2,
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 3,
    parameter int ASZ      = `NS_ADDRESS_SIZE,
    parameter int DSZ      = `NS_DATA_SIZE,
    parameter int RSZ      = `NS_REDUN_SIZE,
    parameter int SRC_BASE = 3,
    parameter int INIT_DAT = 5,
    parameter int INIT_RED = 15,
    parameter int RED_MODE = 0,
    parameter int BW       = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_start,
    input  logic [BW-1:0]      i_burst,
    output logic [NCH*ASZ-1:0] o_src,
    output logic [NCH*ASZ-1:0] o_dst,
    output logic [NCH*DSZ-1:0] o_dat,
    output logic [NCH*RSZ-1:0] o_red,
    output logic [NCH-1:0]     o_req,
    input  logic [NCH-1:0]     i_ack,
    output logic [NCH-1:0]     o_busy,
    output logic [NCH-1:0]     o_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_REQ, ST_REL} state_e;

    localparam int WA = (ASZ > DSZ) ? ASZ : DSZ;
    localparam int WW = (WA > RSZ) ? WA : RSZ;
    localparam logic [ASZ-1:0] MIN_A = ASZ'(MIN_ADDR);
    localparam logic [ASZ-1:0] MAX_A = ASZ'(MAX_ADDR);
    localparam logic [RSZ-1:0] RED_C = RSZ'(INIT_RED);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [ASZ-1:0] SRC_K = ASZ'(SRC_BASE + k);
        localparam logic [DSZ-1:0] DAT_K = DSZ'(INIT_DAT + k);

        state_e         state_q;
        logic [ASZ-1:0] dst_q, dst_d;
        logic [DSZ-1:0] dat_q, cnt_q;
        logic [RSZ-1:0] red_q, red_d;
        logic [BW-1:0]  rem_q;
        logic           cont_q, first_q, req_q, done_q;

        // The sweep restarts at MIN_ADDR only for the very first packet after reset, not on every arm.
        always_comb begin
            dst_d = MIN_A;
            if (!first_q && (dst_q < MAX_A)) begin
                dst_d = dst_q + ASZ'(1);
            end
            red_d = RED_C;
            if (RED_MODE != 0) begin
                red_d = RSZ'(WW'(cnt_q) ^ WW'(dst_d) ^ WW'(SRC_K));
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q <= ST_IDLE;
                dst_q   <= MIN_A;
                dat_q   <= DAT_K;
                cnt_q   <= DAT_K;
                red_q   <= RED_C;
                rem_q   <= '0;
                cont_q  <= 1'b0;
                first_q <= 1'b1;
                req_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (i_en && i_start) begin
                            rem_q   <= i_burst;
                            cont_q  <= (i_burst == '0);
                            state_q <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        // Wait out a stale ack from the previous handshake before raising req.
                        if (!i_ack[k]) begin
                            dst_q   <= dst_d;
                            dat_q   <= cnt_q;
                            cnt_q   <= cnt_q + DSZ'(1);
                            red_q   <= red_d;
                            first_q <= 1'b0;
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (i_ack[k]) begin
                            req_q <= 1'b0;
                            if (!cont_q) begin
                                rem_q <= rem_q - BW'(1);
                            end
                            state_q <= ST_REL;
                        end
                    end
                    ST_REL: begin
                        if (!i_ack[k]) begin
                            if (!cont_q && (rem_q == '0)) begin
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else if (!i_en) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_LOAD;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end

        assign o_src[k*ASZ +: ASZ] = SRC_K;
        assign o_dst[k*ASZ +: ASZ] = dst_q;
        assign o_dat[k*DSZ +: DSZ] = dat_q;
        assign o_red[k*RSZ +: RSZ] = red_q;
        assign o_req[k]            = req_q;
        assign o_done[k]           = done_q;
        assign o_busy[k]           = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_pakout_gen.sv
// Directed bench for pakout_gen: packet fields are checked against a per-channel sweep/counter model.
`timescale 1ns/1ps

module tb_pakout_gen;

    localparam int NCH = 2;
    localparam int ASZ = 4;
    localparam int DSZ = 8;
    localparam int RSZ = 4;
    localparam int BW  = 16;
    localparam int MIN_ADDR = 1;
    localparam int MAX_ADDR = 3;

    logic clk = 1'b0;
    logic rst_n, en, start;
    logic [BW-1:0] burst;
    logic [NCH-1:0] ack, r_ack, auto_ack;

    logic [NCH*ASZ-1:0] o_src, o_dst, r_src, r_dst;
    logic [NCH*DSZ-1:0] o_dat;
    logic [NCH*4-1:0]   r_dat;
    logic [NCH*RSZ-1:0] o_red, r_red;
    logic [NCH-1:0]     o_req, o_busy, o_done, r_req, r_busy, r_done;

    always #5 clk = ~clk;

    pakout_gen #(.NCH(NCH), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .BW(BW)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_burst(burst),
        .o_src(o_src), .o_dst(o_dst), .o_dat(o_dat), .o_red(o_red),
        .o_req(o_req), .i_ack(ack), .o_busy(o_busy), .o_done(o_done)
    );

    pakout_gen #(.NCH(NCH), .ASZ(4), .DSZ(4), .RSZ(4), .RED_MODE(1), .BW(BW)) u_red (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_burst(burst),
        .o_src(r_src), .o_dst(r_dst), .o_dat(r_dat), .o_red(r_red),
        .o_req(r_req), .i_ack(r_ack), .o_busy(r_busy), .o_done(r_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int hs[NCH];
    int done_pls[NCH];
    int done_cyc[NCH];
    logic [ASZ-1:0] exp_dst[NCH];
    logic [DSZ-1:0] exp_dat[NCH];
    logic [15:0]    held[NCH];
    logic [NCH-1:0] prev_req, prev_done;
    int h0, h1, q1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < NCH; k++) begin
            exp_dst[k] = ASZ'(MIN_ADDR);
            exp_dat[k] = DSZ'(5 + k);
        end
        prev_req  = '0;
        prev_done = '0;
    endtask

    function automatic logic [15:0] fields(input int k);
        return {o_dst[k*ASZ +: ASZ], o_dat[k*DSZ +: DSZ], o_red[k*RSZ +: RSZ]};
    endfunction

    // One cycle per step: sample at the falling edge, score new packets and holds, then respond.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) begin
                if (o_req[k] && !prev_req[k]) begin
                    hs[k]++;
                    chk("pkt_dst", 32'(o_dst[k*ASZ +: ASZ]), 32'(exp_dst[k]));
                    chk("pkt_dat", 32'(o_dat[k*DSZ +: DSZ]), 32'(exp_dat[k]));
                    chk("pkt_red", 32'(o_red[k*RSZ +: RSZ]), 32'd15);
                    exp_dst[k] = (exp_dst[k] < ASZ'(MAX_ADDR)) ? exp_dst[k] + 4'd1 : ASZ'(MIN_ADDR);
                    exp_dat[k] = exp_dat[k] + 8'd1;
                    held[k] = fields(k);
                end else if (o_req[k]) begin
                    chk("hold_fields", 32'(fields(k)), 32'(held[k]));
                end
                if (o_done[k]) begin
                    done_cyc[k]++;
                    chk("done_after_idle", 32'(o_busy[k]), 32'd0);
                end
                if (o_done[k] && !prev_done[k]) done_pls[k]++;
                prev_req[k]  = o_req[k];
                prev_done[k] = o_done[k];
                if (auto_ack[k]) ack[k] = o_req[k];
            end
        end
    endtask

    task automatic wait_req(input int k, input string tag);
        int n = 0;
        while (!o_req[k] && n < 20) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(o_req[k]), 32'd1);
    endtask

    task automatic arm(input logic [BW-1:0] b);
        en    = 1'b1;
        burst = b;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; start = 1'b0; burst = '0;
        ack = '0; r_ack = '0; auto_ack = '0;
        for (int k = 0; k < NCH; k++) begin
            hs[k] = 0; done_pls[k] = 0; done_cyc[k] = 0; held[k] = '0;
        end
        reset_model();
        tick(2);

        chk("rst_req",  32'(o_req),  32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        chk("rst_dst",  32'(o_dst),  32'h11);
        chk("rst_dat",  32'(o_dat),  32'h0605);
        chk("rst_red",  32'(o_red),  32'hFF);
        chk("rst_src",  32'(o_src),  32'h43);
        chk("rst_r_busy_done", 32'({r_busy, r_done}), 32'h0);

        rst_n = 1'b1;
        tick(5);
        chk("idle_no_req",  32'(o_req),  32'h0);
        chk("idle_no_busy", 32'(o_busy), 32'h0);

        // Continuous mode with an immediate responder on both channels.
        auto_ack = 2'b11;
        arm('0);
        chk("arm_load_busy", 32'(o_busy), 32'h3);
        chk("arm_load_req",  32'(o_req),  32'h0);
        tick(1);
        chk("arm_req", 32'(o_req), 32'h3);
        chk("red_xor", 32'(r_red), 32'h37);
        chk("red_dst", 32'(r_dst), 32'h11);
        chk("red_dat", 32'(r_dat), 32'h65);
        chk("red_src_req", 32'({r_src, r_req}), 32'h10F);
        tick(1);
        chk("period_rel", 32'(o_req), 32'h0);
        tick(1);
        chk("period_load", 32'(o_req), 32'h0);
        tick(1);
        chk("period_req", 32'(o_req), 32'h3);
        tick(9);
        chk("cont_pkts0", 32'(hs[0]), 32'd5);
        chk("cont_pkts1", 32'(hs[1]), 32'd5);
        chk("cont_no_done", 32'(done_pls[0] + done_pls[1]), 32'd0);
        en = 1'b0;
        tick(4);
        chk("cont_stop_idle", 32'(o_busy), 32'h0);

        // Counted burst; a re-arm while busy must not extend it.
        h0 = hs[0]; h1 = hs[1];
        arm(16'd3);
        tick(3);
        arm(16'd5);
        tick(15);
        chk("burst_pkts0", 32'(hs[0] - h0), 32'd3);
        chk("burst_pkts1", 32'(hs[1] - h1), 32'd3);
        chk("burst_done0", 32'(done_pls[0]), 32'd1);
        chk("burst_done1", 32'(done_pls[1]), 32'd1);
        chk("burst_idle",  32'(o_busy), 32'h0);

        // Stale ack holds ch0 in LOAD; then stall ch0 in REQ while ch1 keeps running.
        auto_ack = 2'b10;
        ack[0] = 1'b1;
        arm('0);
        tick(3);
        chk("load_hold_req",  32'(o_req[0]),  32'd0);
        chk("load_hold_busy", 32'(o_busy[0]), 32'd1);
        ack[0] = 1'b0;
        wait_req(0, "stall_req_rise");
        q1 = hs[1];
        tick(20);
        chk("stall_req_held", 32'(o_req[0]), 32'd1);
        chk("stall_ch1_runs", 32'((hs[1] - q1) >= 6), 32'd1);
        en = 1'b0;
        tick(3);
        chk("endrop_no_abort", 32'(o_req[0]), 32'd1);
        auto_ack[0] = 1'b1;
        tick(6);
        chk("endrop_idle", 32'(o_busy), 32'h0);
        h0 = hs[0]; h1 = hs[1];
        tick(5);
        chk("endrop_no_req", 32'(hs[0] + hs[1]), 32'(h0 + h1));
        chk("endrop_no_done", 32'(done_pls[0] + done_pls[1]), 32'd2);

        // Enable dropped while the last burst packet is in flight still reports completion.
        auto_ack = 2'b10;
        ack[0] = 1'b0;
        arm(16'd1);
        wait_req(0, "last_req_rise");
        en = 1'b0;
        tick(2);
        auto_ack[0] = 1'b1;
        tick(6);
        chk("last_done0", 32'(done_pls[0]), 32'd2);
        chk("last_done1", 32'(done_pls[1]), 32'd2);
        chk("last_idle",  32'(o_busy), 32'h0);

        // Asynchronous reset in the middle of a request.
        auto_ack = 2'b10;
        ack[0] = 1'b0;
        arm('0);
        wait_req(0, "rstmid_req_rise");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_req",  32'(o_req),  32'h0);
        chk("rstmid_busy", 32'(o_busy), 32'h0);
        chk("rstmid_dst",  32'(o_dst),  32'h11);
        chk("rstmid_dat",  32'(o_dat),  32'h0605);
        chk("rstmid_red",  32'(o_red),  32'hFF);
        reset_model();
        en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        auto_ack = 2'b11;
        h0 = hs[0];
        arm(16'd2);
        tick(10);
        chk("post_rst_pkts", 32'(hs[0] - h0), 32'd2);
        chk("post_rst_done", 32'(done_pls[0] + done_pls[1]), 32'd6);
        chk("post_rst_idle", 32'(o_busy), 32'h0);
        chk("done_width0", 32'(done_cyc[0]), 32'(done_pls[0]));
        chk("done_width1", 32'(done_cyc[1]), 32'(done_pls[1]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pakout_gen.md
# pakout_gen

Parametrised multi-channel packet source, successor to the single-channel debug packet emitter. It drives NCH independent output channels over the four-phase req/ack handshake. Each channel sweeps its destination address over [MIN_ADDR, MAX_ADDR], carries an incrementing data counter, and supports both continuous and counted-burst modes. It sits at the edge of the network fabric as a traffic generator for bring-up and for soak tests of pakin/router blocks.

## Interface
Parameters:
- NCH, 2, number of output channels
- MIN_ADDR, 1, lowest destination address in the sweep
- MAX_ADDR, 3, highest destination address in the sweep; MAX_ADDR >= MIN_ADDR
- ASZ, `NS_ADDRESS_SIZE, address width
- DSZ, `NS_DATA_SIZE, data width
- RSZ, `NS_REDUN_SIZE, redundancy field width
- SRC_BASE, 3, source address of channel 0; channel k uses SRC_BASE+k
- INIT_DAT, 5, reset value of channel 0 data counter; channel k uses INIT_DAT+k
- INIT_RED, 15, constant redundancy value when RED_MODE=0
- RED_MODE, 0, redundancy mode: 0 = constant INIT_RED, 1 = computed XOR
- BW, 16, burst counter width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset; asynchronous assert, active-low
- i_en  in  1  global run enable
- i_start  in  1  arms idle channels, one-cycle pulse
- i_burst  in  BW  packets per channel at arm; 0 = continuous
- o_src  out  NCH*ASZ  per-channel source field; channel k at [k*ASZ +: ASZ]
- o_dst  out  NCH*ASZ  per-channel destination field
- o_dat  out  NCH*DSZ  per-channel data field
- o_red  out  NCH*RSZ  per-channel redundancy field
- o_req  out  NCH  per-channel request
- i_ack  in  NCH  per-channel acknowledge
- o_busy  out  NCH  channel not in IDLE
- o_done  out  NCH  one-cycle pulse when a burst completes

## Operation
- Reset values:
  - o_req=0, o_busy=0, o_done=0.
  - o_src[k]=SRC_BASE+k.
  - o_dst[k]=MIN_ADDR.
  - o_dat[k]=INIT_DAT+k (mod 2^DSZ).
  - o_red[k]=INIT_RED.
  - Data counters = INIT_DAT+k.
  - Remaining count = 0; continuous flag = 0.
- Per-channel FSM with states IDLE, LOAD, REQ, REL. Channels are fully independent apart from the shared i_en, i_start and i_burst.
- IDLE → LOAD:
  - When i_en=1 and i_start=1, load remaining=i_burst and set continuous=(i_burst==0).
  - i_start is ignored by any channel not in IDLE, and is ignored entirely when i_en=0.
- LOAD: latch o_dst, o_dat and o_red for the next packet.
  - First packet after reset uses dst=MIN_ADDR. Each later packet uses next(dst) = (dst<MAX_ADDR) ? dst+1 : MIN_ADDR.
  - o_dat = data counter; the counter then increments mod 2^DSZ.
  - RED_MODE=1: o_red = trunc/zero-extend to RSZ of (dat ^ dst ^ src), computed from the newly latched values.
  - LOAD → REQ only when i_ack[k]=0; otherwise the channel stays in LOAD.
- REQ: o_req[k]=1. o_dst, o_dat and o_red are stable for the whole time o_req is high.
  - Stay in REQ while i_ack=0.
  - On i_ack=1: go to REL and, if not continuous, decrement remaining.
- REL: o_req[k]=0; wait for i_ack=0. Then:
  - If i_en=0: go to IDLE with no done pulse, unless remaining just reached 0.
  - Else if continuous, or remaining>0: go to LOAD.
  - Else: go to IDLE and pulse o_done[k] for one cycle.
- i_en deassertion never aborts an in-flight handshake. The channel completes REQ/REL, then returns to IDLE.
- Asynchronous reset in any state forces reset values immediately, including o_req=0 mid-REQ.
- MIN_ADDR==MAX_ADDR: dst stays MIN_ADDR.
- o_busy[k]=1 in LOAD, REQ and REL.

## Timing
- Arm to first request: i_start sampled at edge n → LOAD after n → REQ (o_req=1) after edge n+1.
- Ack to request drop: i_ack high sampled at edge m → o_req=0 after m.
- Next packet: i_ack low sampled in REL at edge p → LOAD → o_req=1 after edge p+1.
- Minimum packet period is 3 cycles with a responder that raises ack 0 cycles after req and lowers it 0 cycles after req falls.
- o_done is asserted the cycle after the REL→IDLE edge, for exactly one cycle.
- Fields change only on the LOAD exit edge, never while o_req=1.

## Test plan
- Reset: hold i_rst_n=0 → all o_req=0, o_busy=0, o_dst=1, o_dat[0]=5, o_dat[1]=6, o_red=15, o_src[0]=3, o_src[1]=4. Release reset → no activity until i_start.
- Continuous: i_en=1, i_start with i_burst=0, ideal responder on ch0 → dst sequence 1,2,3,1,2; dat 5,6,7,8,9; req period 3 cycles; o_done never pulses.
- Burst: i_burst=3 → exactly 3 req/ack handshakes per channel, one o_done pulse each, o_busy=0 after; a second i_start while busy is ignored.
- Stall: hold i_ack[0]=0 for 20 cycles → o_req[0] stays 1 and fields stay constant; ch1 continues unaffected.
- Enable drop and reset: drop i_en mid-REQ → packet completes, then IDLE with no further req. Assert i_rst_n=0 mid-REQ → o_req drops asynchronously, and fields return to reset values.
- RED_MODE=1 with DSZ=RSZ=ASZ=4, ch0 first packet (src=3, dst=1, dat=5) → o_red = 3^1^5 = 7.
